// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and shared constants for the GPIO core
package gpio_pkg;
    localparam int GPIO_ADDR_W = 3;
    localparam logic [GPIO_ADDR_W-1:0] ADDR_OUT      = 3'd0;
    localparam logic [GPIO_ADDR_W-1:0] ADDR_DIR      = 3'd1;
    localparam logic [GPIO_ADDR_W-1:0] ADDR_IN       = 3'd2;
    localparam logic [GPIO_ADDR_W-1:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [GPIO_ADDR_W-1:0] ADDR_IRQ_STAT = 3'd4;
    localparam logic [GPIO_ADDR_W-1:0] ADDR_IRQ_TYPE = 3'd5;
    localparam logic [31:0] RD_DEFAULT = 32'h0;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: single-pin synchroniser, debouncer and edge pulse generator
module gpio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic stable_q, stable_d, prev_q;
    logic diff;
    // The counter must see DEBOUNCE_CYCLES differing cycles before the change is taken.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pin_i};
        diff     = sync_q[SYNC_STAGES-1] != stable_q;
        cnt_d    = (!diff || cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        stable_d = (diff && cnt_q == CNT_MAX) ? sync_q[SYNC_STAGES-1] : stable_q;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
        end
    end
    assign stable_o = stable_q;
    assign rise_o   = stable_q & ~prev_q;
    assign fall_o   = ~stable_q & prev_q;
endmodule

// File: rtl/gpio_core.sv
// gpio_core: GPIO register file, pin drivers, debounced inputs and edge interrupt
module gpio_core
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH      = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   reg_wr_en,
    input  logic [GPIO_ADDR_W-1:0] reg_wr_addr,
    input  logic [31:0]            reg_wr_data,
    input  logic                   reg_rd_en,
    input  logic [GPIO_ADDR_W-1:0] reg_rd_addr,
    output logic [31:0]            reg_rd_data,
    input  logic [GPIO_WIDTH-1:0]  gpio_i,
    output logic [GPIO_WIDTH-1:0]  gpio_o,
    output logic [GPIO_WIDTH-1:0]  gpio_oe,
    output logic                   irq
);
    logic [GPIO_WIDTH-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d;
    logic [GPIO_WIDTH-1:0] stat_q, stat_d, type_q, type_d;
    logic [GPIO_WIDTH-1:0] in_v, rise_v, fall_v, set_v, wd, clr_v;
    logic [31:0] rd_q, rd_d, rd_sel;
    logic irq_q, irq_d, unused_wr;
    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
        gpio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i   (ACLK),
            .rst_ni  (ARESETN),
            .pin_i   (gpio_i[i]),
            .stable_o(in_v[i]),
            .rise_o  (rise_v[i]),
            .fall_o  (fall_v[i])
        );
    end
    assign unused_wr = ^reg_wr_data;
    always_comb begin
        wd     = reg_wr_data[GPIO_WIDTH-1:0];
        out_d  = (reg_wr_en && reg_wr_addr == ADDR_OUT) ? wd : out_q;
        dir_d  = (reg_wr_en && reg_wr_addr == ADDR_DIR) ? wd : dir_q;
        en_d   = (reg_wr_en && reg_wr_addr == ADDR_IRQ_EN) ? wd : en_q;
        type_d = (reg_wr_en && reg_wr_addr == ADDR_IRQ_TYPE) ? wd : type_q;
        clr_v  = (reg_wr_en && reg_wr_addr == ADDR_IRQ_STAT) ? wd : '0;
        set_v  = ((rise_v & type_q) | (fall_v & ~type_q)) & ~dir_q;
        stat_d = (stat_q & ~clr_v) | set_v;
        irq_d  = |(stat_q & en_q);
        case (reg_rd_addr)
            ADDR_OUT:      rd_sel = 32'(out_q);
            ADDR_DIR:      rd_sel = 32'(dir_q);
            ADDR_IN:       rd_sel = 32'(in_v);
            ADDR_IRQ_EN:   rd_sel = 32'(en_q);
            ADDR_IRQ_STAT: rd_sel = 32'(stat_q);
            ADDR_IRQ_TYPE: rd_sel = 32'(type_q);
            default:       rd_sel = RD_DEFAULT;
        endcase
        rd_d = reg_rd_en ? rd_sel : rd_q;
    end
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            out_q  <= '0;
            dir_q  <= '0;
            en_q   <= '0;
            stat_q <= '0;
            type_q <= '0;
            rd_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            en_q   <= en_d;
            stat_q <= stat_d;
            type_q <= type_d;
            rd_q   <= rd_d;
            irq_q  <= irq_d;
        end
    end
    assign gpio_o      = out_q;
    assign gpio_oe     = dir_q;
    assign irq         = irq_q;
    assign reg_rd_data = rd_q;
endmodule
